pool_window_gen: RTL and testbench

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

---
 rtl/pool_window_gen.sv | 167 ++++++++++++++++
 tb/tb_pool_window_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// pool_window_gen
// Turns a raster stream of pixel words into 2x2 max-pool window beats.
// Even rows are parked in a one-line buffer. Each odd-row pixel emits two
// beats: the buffered pixel above it, then the pixel itself. Beats arrive as
// buf[2k], cur[2k], buf[2k+1], cur[2k+1], which brackets every window with
// exactly one first_data beat and one last_data beat.
module pool_window_gen #(
  parameter int INPUT_NUM = 6,
  parameter int WDP       = 9,
  parameter int IMG_W     = 24,
  parameter int IMG_H     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WDP*INPUT_NUM-1:0] in_data,
  output logic                     in_ready,
  output logic                     en,
  output logic                     first_data,
  output logic                     last_data,
  output logic [WDP*INPUT_NUM-1:0] data_o,
  output logic                     frame_done
);

  localparam int DW = WDP * INPUT_NUM;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    RECV     = 2'd0,
    EMIT_BUF = 2'd1,
    EMIT_CUR = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [DW-1:0] line_mem [IMG_W];
  logic [DW-1:0] cur_reg;
  logic          col_odd_reg;    // column parity of the pixel being emitted
  logic          frame_end_reg;  // pixel being emitted is the last of the frame

  logic accept;
  logic odd_row;
  logic col_last;
  logic row_last;

  logic en_next;
  logic first_next;
  logic last_next;
  logic done_next;
  logic load_buf;
  logic load_cur;

  assign accept   = in_valid & in_ready;
  assign odd_row  = row_reg[0];
  assign col_last = (col_reg == CW'(IMG_W - 1));
  assign row_last = (row_reg == RW'(IMG_H - 1));

  // State register; reset drops any half-emitted window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RECV;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: an odd-row pixel triggers the two-beat emit sequence.
  // in_valid is used directly since in_ready is always 1 in RECV.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RECV:     if (in_valid && odd_row) state_next = EMIT_BUF;
      EMIT_BUF: state_next = EMIT_CUR;
      EMIT_CUR: state_next = RECV;
      default:  state_next = RECV;
    endcase
  end

  // Outputs: in_ready plus the values the output registers load at this edge.
  always_comb begin
    in_ready   = 1'b0;
    en_next    = 1'b0;
    first_next = 1'b0;
    last_next  = 1'b0;
    done_next  = 1'b0;
    load_buf   = 1'b0;
    load_cur   = 1'b0;
    case (state_reg)
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && odd_row) begin
          en_next    = 1'b1;
          first_next = ~col_reg[0];
          load_buf   = 1'b1;
        end
      end
      EMIT_BUF: begin
        en_next   = 1'b1;
        last_next = col_odd_reg;
        done_next = col_odd_reg & frame_end_reg;
        load_cur  = 1'b1;
      end
      default: ;
    endcase
  end

  // Raster position of the next accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  // Capture the odd-row pixel and the window facts needed on its second beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_reg       <= '0;
      col_odd_reg   <= 1'b0;
      frame_end_reg <= 1'b0;
    end else if (accept && odd_row) begin
      cur_reg       <= in_data;
      col_odd_reg   <= col_reg[0];
      frame_end_reg <= col_last & row_last;
    end
  end

  // Line buffer write port: even rows only.
  always_ff @(posedge clk) begin
    if (accept && !odd_row) begin
      line_mem[col_reg] <= in_data;
    end
  end

  // Registered beat outputs; data_o holds its last beat while en is low and
  // doubles as the synchronous read register of the line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      en         <= 1'b0;
      first_data <= 1'b0;
      last_data  <= 1'b0;
      frame_done <= 1'b0;
      data_o     <= '0;
    end else begin
      en         <= en_next;
      first_data <= first_next;
      last_data  <= last_next;
      frame_done <= done_next;
      if (load_buf) begin
        data_o <= line_mem[col_reg];
      end else if (load_cur) begin
        data_o <= cur_reg;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen on a 4x2 single-plane image.
// The driver pushes hand-written expected beats into a queue; a monitor on
// the falling edge pops and compares whenever en is high, and checks that
// idle cycles keep data_o held with all flags low.
module tb_pool_window_gen;

  typedef logic signed [8:0] vec8_t [8];

  typedef struct packed {
    logic [8:0] d;
    logic       f;
    logic       l;
    logic       fd;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_ready;
  logic       en;
  logic       first_data;
  logic       last_data;
  logic [8:0] data_o;
  logic       frame_done;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    busy_cnt = 0;
  int    done_cnt = 0;
  int    rst_cnt = 0;
  int    rst_cnt_seen = 0;
  logic [8:0] last_seen = '0;

  pool_window_gen #(
    .INPUT_NUM(1),
    .WDP      (9),
    .IMG_W    (4),
    .IMG_H    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .en        (en),
    .first_data(first_data),
    .last_data (last_data),
    .data_o    (data_o),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    beat_t e;
    if (rst_cnt != rst_cnt_seen) begin
      rst_cnt_seen = rst_cnt;
      last_seen = '0;
    end
    if (!rst) begin
      if (!in_ready) busy_cnt++;
      if (en) begin
        if (frame_done) done_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: got d=%0d f=%0b l=%0b fd=%0b, required no beat",
                   $signed(data_o), first_data, last_data, frame_done);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e.d || first_data !== e.f || last_data !== e.l || frame_done !== e.fd) begin
            fails++;
            $display("FAIL beat: got d=%0d f=%0b l=%0b fd=%0b, required d=%0d f=%0b l=%0b fd=%0b",
                     $signed(data_o), first_data, last_data, frame_done,
                     $signed(e.d), e.f, e.l, e.fd);
          end else begin
            $display("[TB] beat d=%0d f=%0b l=%0b fd=%0b ok",
                     $signed(data_o), first_data, last_data, frame_done);
          end
        end
        last_seen = data_o;
      end else begin
        tests++;
        if (first_data !== 1'b0 || last_data !== 1'b0 || frame_done !== 1'b0 || data_o !== last_seen) begin
          fails++;
          $display("FAIL idle_hold: got d=%0d f=%0b l=%0b fd=%0b, required d=%0d and flags 0",
                   $signed(data_o), first_data, last_data, frame_done, $signed(last_seen));
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end else begin
      $display("[TB] %s = %0d ok", nm, act);
    end
  endtask

  task automatic send_pixel(input logic [8:0] v, input bit gap);
    int t;
    in_valid = 1'b1;
    in_data  = v;
    t = 0;
    while (!in_ready && t < 16) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: in_ready got 0, required 1 within 16 cycles");
    end
    @(posedge clk); #1;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Flag pattern for beats 0..7 of a 4x2 frame is fixed.
  task automatic push_frame(input vec8_t ex);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.d  = ex[i];
      b.f  = (i == 0 || i == 4);
      b.l  = (i == 3 || i == 7);
      b.fd = (i == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic run_frame(input vec8_t px, input vec8_t ex, input bit gap);
    push_frame(ex);
    for (int i = 0; i < 8; i++) send_pixel(px[i], gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec8_t px_a, ex_a, px_n, ex_n, px_b, ex_b;
    beat_t b;
    int b0;
    int d0;

    px_a = '{9'sd1, 9'sd2, 9'sd3, 9'sd4, 9'sd5, 9'sd6, 9'sd7, 9'sd8};
    ex_a = '{9'sd1, 9'sd5, 9'sd2, 9'sd6, 9'sd3, 9'sd7, 9'sd4, 9'sd8};
    px_n = '{-9'sd1, -9'sd5, -9'sd3, -9'sd2, -9'sd7, -9'sd4, -9'sd6, -9'sd8};
    ex_n = '{-9'sd1, -9'sd7, -9'sd5, -9'sd4, -9'sd3, -9'sd6, -9'sd2, -9'sd8};
    px_b = '{9'sd11, 9'sd12, 9'sd13, 9'sd14, 9'sd15, 9'sd16, 9'sd17, 9'sd18};
    ex_b = '{9'sd11, 9'sd15, 9'sd12, 9'sd16, 9'sd13, 9'sd17, 9'sd14, 9'sd18};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_en", int'(en), 0);
    chk("reset_data_o", int'(data_o), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Full frame, in_valid held high
    b0 = busy_cnt;
    run_frame(px_a, ex_a, 1'b0);
    in_valid = 1'b0;
    drain();
    chk("busy_cycles_frame", busy_cnt - b0, 8);

    // Negative values pass unchanged
    run_frame(px_n, ex_n, 1'b0);
    in_valid = 1'b0;
    drain();

    // Throttled input
    run_frame(px_a, ex_a, 1'b1);
    in_valid = 1'b0;
    drain();

    // Reset right after the beat carrying 5
    b.d = 9'd1; b.f = 1'b1; b.l = 1'b0; b.fd = 1'b0;
    exp_q.push_back(b);
    b.d = 9'd5; b.f = 1'b0; b.l = 1'b0; b.fd = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < 5; i++) send_pixel(px_a[i], 1'b0);
    in_valid = 1'b0;
    chk("latency_buf_en", int'(en), 1);
    chk("latency_buf_data", int'(data_o), 1);
    @(posedge clk); #1;
    chk("latency_cur_data", int'(data_o), 5);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_en", int'(en), 0);
    chk("post_reset_data_o", int'(data_o), 0);
    chk("post_reset_in_ready", int'(in_ready), 1);
    chk("post_reset_pending", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    run_frame(px_a, ex_a, 1'b0);
    in_valid = 1'b0;
    drain();

    // Back-to-back frames
    d0 = done_cnt;
    run_frame(px_a, ex_a, 1'b0);
    run_frame(px_b, ex_b, 1'b0);
    in_valid = 1'b0;
    drain();
    chk("frame_done_pulses", done_cnt - d0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
